// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver.
// sck, sdi and cs are oversampled in the clk domain. Complete frames of
// NBYTES bytes are delivered as one-cycle events. Byte 0 is the command
// byte and is received MSB first.
//
// Handshake: frame_valid and frame_err are single-cycle strobes with no
// back-pressure. frame is held stable from one frame_valid pulse until
// the next one. The two strobes are never high in the same cycle.
module spi_frame_rx #(
    parameter int NBYTES      = 3,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  cs,
    output logic [8*NBYTES-1:0]   frame,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int NBITS = 8 * NBYTES;
    localparam int CW    = $clog2(NBITS + 1);

    localparam logic [CW-1:0] NBITS_C     = CW'(NBITS);
    localparam logic          SCK_IDLE    = (CPOL != 0);
    // Modes 0 and 3 sample on the rising edge. Modes 1 and 2 sample on the falling edge.
    localparam logic          SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Reset is asserted asynchronously and released synchronously to clk.
    logic [1:0] rst_pipe;
    logic       rst_int_n;

    // Two-flop reset release synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_int_n = rst_pipe[1];

    // Input synchronisers, plus one extra copy of sck and cs for edge detection.
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_last;
    logic                   cs_last;

    // Shift the pins through the synchroniser chains.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sck_sync <= {SYNC_STAGES{SCK_IDLE}};
            sdi_sync <= '0;
            cs_sync  <= '0;
            sck_last <= SCK_IDLE;
            cs_last  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
            sck_last <= sck_sync[SYNC_STAGES-1];
            cs_last  <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sck_s;
    logic sdi_s;
    logic cs_s;
    logic sample_edge;
    logic cs_rise;
    logic cs_fall;

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign sample_edge = SAMPLE_RISE ? (sck_s & ~sck_last) : (~sck_s & sck_last);
    assign cs_rise     = cs_s & ~cs_last;
    assign cs_fall     = ~cs_s & cs_last;

    state_t             state;
    state_t             state_n;
    logic [NBITS-1:0]   shift_q;
    logic [NBITS-1:0]   shift_n;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_n;
    logic               ovr_q;
    logic               ovr_n;
    logic [NBITS-1:0]   frame_n;
    logic               valid_n;
    logic               err_n;

    // State register, datapath registers and registered output strobes.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            shift_q     <= shift_n;
            cnt_q       <= cnt_n;
            ovr_q       <= ovr_n;
            frame       <= frame_n;
            frame_valid <= valid_n;
            frame_err   <= err_n;
        end
    end

    // Next state, shift and count, frame capture and strobe generation.
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        cnt_n   = cnt_q;
        ovr_n   = ovr_q;
        frame_n = frame;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                ovr_n = 1'b0;
                if (cs_rise) begin
                    state_n = S_RECV;
                    shift_n = '0;
                    cnt_n   = '0;
                end
            end
            S_RECV: begin
                if (cnt_q == NBITS_C) begin
                    // The frame is complete, even if cs drops in this same cycle.
                    frame_n = shift_q;
                    valid_n = 1'b1;
                    state_n = cs_fall ? S_IDLE : S_DONE;
                end else if (cs_fall) begin
                    // cs falling wins over a coincident sample edge.
                    err_n   = (cnt_q != '0);
                    state_n = S_IDLE;
                end else if (sample_edge) begin
                    shift_n = {shift_q[NBITS-2:0], sdi_s};
                    cnt_n   = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (cs_fall) begin
                    err_n   = ovr_q;
                    ovr_n   = 1'b0;
                    state_n = S_IDLE;
                end else if (sample_edge) begin
                    ovr_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy = (state == S_RECV);

endmodule
